// File: rtl/regfile_pkg.sv
// Shared constants for the MMIO register file: default geometry and named register indices.
// Window membership helper used by both the RTL and anything that decodes register indices.
package regfile_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int IN_BASE_DEF    = 12;
  localparam int OUT_BASE_DEF   = 17;

  // Input-mirror registers (game -> processor)
  localparam int REG_VAR        = 12;
  localparam int REG_CUR_SCORE  = 13;
  localparam int REG_RX         = 14;
  localparam int REG_RY         = 15;

  // Output registers (processor -> game/VGA)
  localparam int REG_NEXT_SCORE = 17;
  localparam int REG_OFFSET_X   = 18;
  localparam int REG_OFFSET_Y   = 19;

  function automatic logic in_window(input int idx, input int base, input int num);
    return (idx >= base) && (idx < base + num);
  endfunction

endpackage

// File: rtl/regfile_out_chan.sv
// One output channel's handshake state: valid raised by a processor write, cleared by accept.
// Overrun is sticky until reset; an accept coinciding with a new write keeps valid without overrun.
module regfile_out_chan (
  input  logic clock,
  input  logic ctrl_reset_n,
  input  logic wr_hit_i,
  input  logic rdy_i,
  output logic vld_o,
  output logic ovr_o
);

  logic vld_q, vld_d;
  logic ovr_q, ovr_d;

  always_comb begin
    vld_d = vld_q;
    ovr_d = ovr_q;
    if (wr_hit_i) begin
      vld_d = 1'b1;
      // Previous value was never consumed: it has been overwritten.
      if (vld_q && !rdy_i) ovr_d = 1'b1;
    end else if (vld_q && rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      ovr_q <= ovr_d;
    end
  end

  assign vld_o = vld_q;
  assign ovr_o = ovr_q;

endmodule

// File: rtl/regfile_mmio.sv
// 2R/1W register file with a sampled input-mirror window and valid/ready output window; reads combinational, writes land next edge.
// REGFILE_BYPASS_EN: when defined, a same-cycle write to a readable GP/output index is forwarded to the read ports.
module regfile_mmio
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_IN     = 4,
  parameter int IN_BASE    = IN_BASE_DEF,
  parameter int IN_WIDTH   = 11,
  parameter int NUM_OUT    = 3,
  parameter int OUT_BASE   = OUT_BASE_DEF,
  parameter int OUT_WIDTH  = 11
) (
  input  logic                          clock,
  input  logic                          ctrl_reset_n,
  input  logic                          ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]         ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]         data_writeReg,
  input  logic [ADDR_WIDTH-1:0]         ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0]         ctrl_readRegB,
  output logic [DATA_WIDTH-1:0]         data_readRegA,
  output logic [DATA_WIDTH-1:0]         data_readRegB,
  input  logic [NUM_IN*IN_WIDTH-1:0]    in_data,
  input  logic                          in_hold,
  output logic [NUM_OUT*OUT_WIDTH-1:0]  out_data,
  output logic [NUM_OUT-1:0]            out_valid,
  input  logic [NUM_OUT-1:0]            out_ready,
  output logic [NUM_OUT-1:0]            out_overrun
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  if ((IN_BASE < 1) || (OUT_BASE < 1) ||
      (IN_BASE + NUM_IN > NUM_REGS) || (OUT_BASE + NUM_OUT > NUM_REGS) ||
      !((IN_BASE + NUM_IN <= OUT_BASE) || (OUT_BASE + NUM_OUT <= IN_BASE)) ||
      (IN_WIDTH > DATA_WIDTH) || (OUT_WIDTH > DATA_WIDTH)) begin : g_bad_map
    $error("regfile_mmio: mirror/output windows overlap, include r0, exceed the file, or are too wide");
  end

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  wr_gp;

  // Writes to r0 and to the mirror window never land: the sample always wins there.
  assign wr_gp = ctrl_writeEnable && (ctrl_writeReg != '0) &&
                 !in_window(int'(ctrl_writeReg), IN_BASE, NUM_IN);

  always_comb begin
    regs_d = regs_q;
    if (wr_gp) regs_d[ctrl_writeReg] = data_writeReg;
    if (!in_hold) begin
      for (int k = 0; k < NUM_IN; k++) begin
        regs_d[IN_BASE + k] = DATA_WIDTH'(in_data[k*IN_WIDTH +: IN_WIDTH]);
      end
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] val;
    val = (idx == '0) ? '0 : regs_q[idx];
`ifdef REGFILE_BYPASS_EN
    if (wr_gp && (ctrl_writeReg == idx)) val = data_writeReg;
`endif
    return val;
  endfunction

  always_comb begin
    data_readRegA = read_port(ctrl_readRegA);
    data_readRegB = read_port(ctrl_readRegB);
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    logic wr_hit;

    assign wr_hit = ctrl_writeEnable && (ctrl_writeReg == ADDR_WIDTH'(OUT_BASE + k));

    regfile_out_chan u_chan (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .wr_hit_i     (wr_hit),
      .rdy_i        (out_ready[k]),
      .vld_o        (out_valid[k]),
      .ovr_o        (out_overrun[k])
    );

    assign out_data[k*OUT_WIDTH +: OUT_WIDTH] = regs_q[OUT_BASE + k][OUT_WIDTH-1:0];
  end

endmodule

// File: doc/regfile_mmio.md
Name: regfile_mmio

Overview:
- Parametrised register file (2 read, 1 write) for the processor datapath, with a contiguous window of input-mirror registers and a window of output registers with valid/ready handshakes.
- Inputs (game score, cursor coordinates, variant select) are sampled into registers every cycle.
- Processor writes to output registers (next score, X/Y offset) raise per-channel valid to downstream game/VGA logic.

Parameters:
- DATA_WIDTH, 32, register width.
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH.
- NUM_IN, 4, input-mirror channels, mapped to registers IN_BASE..IN_BASE+NUM_IN-1.
- IN_BASE, 12, first input-mirror register index.
- IN_WIDTH, 11, width of each input channel, zero-extended to DATA_WIDTH.
- NUM_OUT, 3, output channels, mapped to registers OUT_BASE..OUT_BASE+NUM_OUT-1.
- OUT_BASE, 17, first output register index.
- OUT_WIDTH, 11, width of each output channel (low bits of the register).

Ports:
- clock  in  1  system clock, rising edge.
- ctrl_reset_n  in  1  asynchronous, active-low reset.
- ctrl_writeEnable  in  1  write strobe.
- ctrl_writeReg  in  ADDR_WIDTH  write index.
- data_writeReg  in  DATA_WIDTH  write data.
- ctrl_readRegA / ctrl_readRegB  in  ADDR_WIDTH  read indices.
- data_readRegA / data_readRegB  out  DATA_WIDTH  read data, combinational.
- in_data  in  NUM_IN*IN_WIDTH  packed input channels; channel k in bits [k*IN_WIDTH +: IN_WIDTH].
- in_hold  in  1  when 1, input mirrors are frozen (no sampling).
- out_data  out  NUM_OUT*OUT_WIDTH  packed low bits of the output registers.
- out_valid  out  NUM_OUT  per-channel pending-update flag.
- out_ready  in  NUM_OUT  per-channel consumer accept.
- out_overrun  out  NUM_OUT  sticky flag: rewritten while still valid.

Behaviour:
- Reset (ctrl_reset_n=0, async): all registers, out_valid and out_overrun go to 0; out_data reads 0. Deassertion takes effect at the next rising edge.
- Register 0 reads 0 always; writes to it are dropped.
- Write: on a rising edge with ctrl_writeEnable=1, register[ctrl_writeReg] <= data_writeReg.
- Input mirrors: each edge with in_hold=0, register[IN_BASE+k] <= zero-extended channel k.
  - Processor writes to mirror indices are dropped; the sample wins.
  - With in_hold=1, mirrors keep their value and processor writes remain dropped.
- Output channel k:
  - A processor write to OUT_BASE+k sets out_valid[k]=1 on the next cycle. If out_valid[k] was already 1 and not accepted that cycle, out_overrun[k] <= 1.
  - Handshake: out_valid[k] & out_ready[k] at an edge clears out_valid[k].
  - Simultaneous accept and new write: out_valid[k] stays 1 with the new data; no overrun.
  - out_overrun[k] clears only on reset.
  - out_data[k] is always the low OUT_WIDTH bits of the register, stable while valid until accepted or rewritten.
- Reads are combinational: register contents, or the forwarded value per the feature below. Mirror reads return the value sampled at the previous edge.
- Index ranges may not overlap or include 0. Violation is checked by an elaboration-time assertion and fails compile.
- Out-of-window indices behave as ordinary general-purpose registers.
- Reset mid-handshake: valid drops immediately, asynchronously. The consumer must tolerate a valid withdrawal only under reset.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: if ctrl_writeEnable=1 and ctrl_writeReg equals a read index (nonzero, not a mirror index), that read port returns data_writeReg in the same cycle (write-through forwarding).
- Undefined: read ports return the stored value (old data) during a same-cycle write.
- No high-impedance output in either mode.

Decomposition:
- Shared package regfile_pkg: DATA_WIDTH/ADDR_WIDTH defaults, default IN_BASE/OUT_BASE, and named index constants:
  - REG_VAR=12, REG_CUR_SCORE=13, REG_RX=14, REG_RY=15 for the inputs.
  - REG_NEXT_SCORE=17, REG_OFFSET_X=18, REG_OFFSET_Y=19 for the outputs.
- One sub-module, regfile_out_chan: per-channel valid/overrun state, instantiated NUM_OUT times via generate.

Test Plan:
- Reset then write 0xDEADBEEF to r5, read A=r5, B=r0 -> next cycle A=0xDEADBEEF, B=0. Write to r0 -> B still 0.
- in_data channel 1 = 11'd700, in_hold=0 -> one edge later r13 reads 700. Set in_hold=1, change to 5 -> r13 stays 700. Processor write to r13 -> ignored.
- Write 0x123 to r17, out_ready=0 -> out_valid[0]=1, out_data[0]=0x123. Hold 3 cycles, then out_ready=1 -> valid clears after one edge.
- Write r18=10, then r18=20 with no ready -> out_overrun[1]=1, out_data[1]=20. Write during an accept edge -> valid stays 1, no overrun.
- Same-cycle write r7=0x55 with read A=r7: with REGFILE_BYPASS_EN A=0x55 that cycle; without it, A shows the old value and 0x55 the next cycle.
- Assert ctrl_reset_n=0 between edges while out_valid=1 -> valid, overrun and registers go to 0 immediately, without waiting for a clock edge.
